// File: rtl/adsr_envelope.sv
// ADSR envelope generator and VCA: per-sample-tick attack/decay/sustain/release on an envelope
// accumulator, sample scaled by the envelope's top 8 bits. Define ADSR_EXP_EN for exponential decay/release.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | envelope parked at 0, waiting for a rising gate
// S_ATTACK  | env ramps up linearly toward full scale
// S_DECAY   | env ramps down toward the sustain target
// S_SUSTAIN | env tracks the sustain target while the gate is held
// S_RELEASE | gate dropped; env ramps down toward 0
module adsr_envelope #(
  parameter int BITDEPTH   = 14,
  parameter int ENVBITS    = 16,
  parameter int RATEBITS   = 8,
  parameter int RATE_SHIFT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic [BITDEPTH-1:0] in,
  input  logic                gate,
  input  logic [RATEBITS-1:0] attack,
  input  logic [RATEBITS-1:0] decay,
  input  logic [RATEBITS-1:0] sustain,
  input  logic [RATEBITS-1:0] release_rate,
  output logic [BITDEPTH-1:0] out,
  output logic                out_valid,
  output logic [2:0]          state,
  output logic                active
);

  localparam int EW = ENVBITS + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                    st;
  state_t                    st_nx;
  logic [ENVBITS-1:0]        env;
  logic [ENVBITS-1:0]        env_nx;
  logic [ENVBITS-1:0]        target;
  logic                      gate_q;
  logic                      tick_q;
  logic [BITDEPTH-1:0]       in_q;
  logic [EW-1:0]             att_step;
  logic [EW-1:0]             dec_step;
  logic [EW-1:0]             rel_step;
  logic [EW-1:0]             att_sum;
  logic [EW-1:0]             dec_diff;
  logic [EW-1:0]             rel_diff;
  logic                      rise;
  logic                      fall;
  logic signed [BITDEPTH+8:0] in_x;
  logic signed [BITDEPTH+8:0] gain_x;
  logic signed [BITDEPTH+8:0] prod;

  function automatic logic [EW-1:0] lin_step(input logic [RATEBITS-1:0] rate);
    return (EW'(rate) + EW'(1)) << RATE_SHIFT;
  endfunction

  assign target   = {sustain, {(ENVBITS-RATEBITS){1'b0}}};
  assign att_step = lin_step(attack);

`ifdef ADSR_EXP_EN
  // Step proportional to the remaining distance; the +1 guarantees the target is always reached.
  logic [ENVBITS-1:0] dec_gap;
  assign dec_gap  = env - target;
  assign dec_step = {1'b0, dec_gap >> decay[3:0]} + EW'(1);
  assign rel_step = {1'b0, env >> release_rate[3:0]} + EW'(1);
`else
  assign dec_step = lin_step(decay);
  assign rel_step = lin_step(release_rate);
`endif

  // One extra bit on each side of the arithmetic exposes carry (attack) and borrow (decay/release).
  assign att_sum  = {1'b0, env} + att_step;
  assign dec_diff = {1'b0, env} - dec_step;
  assign rel_diff = {1'b0, env} - rel_step;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  always_comb begin
    env_nx = env;
    st_nx  = st;
    if (rise) begin
      st_nx = S_ATTACK;
    end else if (fall && (st == S_ATTACK || st == S_DECAY || st == S_SUSTAIN)) begin
      st_nx = S_RELEASE;
    end else begin
      case (st)
        S_IDLE: env_nx = '0;
        S_ATTACK: begin
          if (att_sum[ENVBITS] || (&att_sum[ENVBITS-1:0])) begin
            env_nx = '1;
            st_nx  = S_DECAY;
          end else begin
            env_nx = att_sum[ENVBITS-1:0];
          end
        end
        S_DECAY: begin
          if (dec_diff[ENVBITS] || (dec_diff[ENVBITS-1:0] <= target)) begin
            env_nx = target;
            st_nx  = S_SUSTAIN;
          end else begin
            env_nx = dec_diff[ENVBITS-1:0];
          end
        end
        S_SUSTAIN: env_nx = target;
        S_RELEASE: begin
          if (rel_diff[ENVBITS] || (rel_diff[ENVBITS-1:0] == '0)) begin
            env_nx = '0;
            st_nx  = S_IDLE;
          end else begin
            env_nx = rel_diff[ENVBITS-1:0];
          end
        end
        default: begin
          env_nx = '0;
          st_nx  = S_IDLE;
        end
      endcase
    end
  end

  // Gain is unsigned 0..255; widening both operands keeps the full signed product.
  assign in_x   = {{9{in_q[BITDEPTH-1]}}, in_q};
  assign gain_x = {{(BITDEPTH+1){1'b0}}, env[ENVBITS-1 -: 8]};
  assign prod   = in_x * gain_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      env       <= '0;
      st        <= S_IDLE;
      gate_q    <= 1'b0;
      in_q      <= '0;
      tick_q    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      active    <= 1'b0;
    end else begin
      tick_q    <= sample_en;
      out_valid <= tick_q;
      if (tick_q) begin
        out <= BITDEPTH'(prod >>> 8);
      end
      if (sample_en) begin
        gate_q <= gate;
        in_q   <= in;
        env    <= env_nx;
        st     <= st_nx;
        active <= (st_nx != S_IDLE);
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed ADSR scenarios plus randomized ticks checked
// against an integer reference model of the envelope rules.
module tb_adsr_envelope;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic        gate;
  logic [13:0] smp;
  logic [7:0]  attack;
  logic [7:0]  decay;
  logic [7:0]  sustain;
  logic [7:0]  rel;
  logic [13:0] out;
  logic        out_valid;
  logic [2:0]  state;
  logic        active;

  int checks   = 0;
  int failures = 0;

  int   m_env;
  int   m_state;
  logic m_gq;
  int   m_in;

  localparam logic [13:0] POS = 14'd4096;
  localparam logic [13:0] NEG = 14'h3000;
`ifdef ADSR_EXP_EN
  localparam logic [7:0] DEC_RATE = 8'h04;
`else
  localparam logic [7:0] DEC_RATE = 8'h0F;
`endif

  adsr_envelope dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .in           (smp),
    .gate         (gate),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_rate (rel),
    .out          (out),
    .out_valid    (out_valid),
    .state        (state),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lin_step(int r);
    return (r + 1) * 16;
  endfunction

  function automatic int dec_amt(int e, int tgt, int r);
`ifdef ADSR_EXP_EN
    return ((e - tgt) >> (r % 16)) + 1;
`else
    return lin_step(r);
`endif
  endfunction

  function automatic void model_step();
    int tgt;
    tgt = int'(sustain) * 256;
    if (gate && !m_gq) begin
      m_state = 1;
    end else if (!gate && m_gq && m_state >= 1 && m_state <= 3) begin
      m_state = 4;
    end else begin
      case (m_state)
        1: begin
          if (m_env + lin_step(int'(attack)) >= 65535) begin
            m_env = 65535; m_state = 2;
          end else m_env = m_env + lin_step(int'(attack));
        end
        2: begin
          if (m_env <= tgt || m_env - dec_amt(m_env, tgt, int'(decay)) <= tgt) begin
            m_env = tgt; m_state = 3;
          end else m_env = m_env - dec_amt(m_env, tgt, int'(decay));
        end
        3: m_env = tgt;
        4: begin
          if (m_env <= dec_amt(m_env, 0, int'(rel))) begin
            m_env = 0; m_state = 0;
          end else m_env = m_env - dec_amt(m_env, 0, int'(rel));
        end
        default: m_env = 0;
      endcase
    end
    m_gq = gate;
    m_in = int'($signed(smp));
  endfunction

  function automatic int m_out();
    return (m_in * (m_env / 256)) >>> 8;
  endfunction

  function automatic int dut_out();
    return int'($signed(out));
  endfunction

  task automatic tick();
    @(negedge clk);
    sample_en = 1'b1;
    model_step();
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    sample_en = 1'b0;
    m_env = 0; m_state = 0; m_gq = 1'b0; m_in = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out !== 14'd0) begin failures++; $display("FAIL reset_out got=%0d want=0", dut_out()); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b want=0", active); end
    @(negedge clk); rst = 1'b1;
    gate = 1'b1; smp = POS; attack = 8'hFF;
    repeat (3) tick();
    checks++; if (dut_out() !== 512) begin failures++; $display("FAIL pre_reset_out got=%0d want=512", dut_out()); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (out !== 14'd0) begin failures++; $display("FAIL midreset_out got=%0d want=0", dut_out()); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%0b want=0", out_valid); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL midreset_state got=%0d want=0", state); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL midreset_active got=%0b want=0", active); end
    m_env = 0; m_state = 0; m_gq = 1'b0; m_in = 0;
    @(negedge clk); rst = 1'b1;
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL gate_held_state got=%0d want=1", state); end
    checks++; if (dut_out() !== 0) begin failures++; $display("FAIL gate_held_out got=%0d want=0", dut_out()); end
    gate = 1'b0;
    apply_reset();
  endtask

  task automatic test_attack();
    attack = 8'hFF; decay = DEC_RATE; sustain = 8'h80; rel = 8'h07; smp = POS;
    tick();
    gate = 1'b1;
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL attack_edge_state got=%0d want=1", state); end
    checks++; if (dut_out() !== 0) begin failures++; $display("FAIL attack_edge_out got=%0d want=0", dut_out()); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (dut_out() !== m_out()) begin failures++; $display("FAIL attack_out k=%0d got=%0d want=%0d", k, dut_out(), m_out()); end
      if (k == 8) begin
        checks++; if (dut_out() !== 2048) begin failures++; $display("FAIL attack_k8_out got=%0d want=2048", dut_out()); end
      end
      if (k == 15) begin
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL attack_k15_state got=%0d want=1", state); end
      end
    end
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL attack_done_state got=%0d want=2", state); end
    checks++; if (dut_out() !== 4080) begin failures++; $display("FAIL attack_max_out got=%0d want=4080", dut_out()); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL valid_high got=%0b want=1", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL valid_pulse got=%0b want=0", out_valid); end
  endtask

  task automatic test_decay_sustain();
    int k;
    k = 0;
    while (m_state == 2 && k < 2000) begin
      tick();
      k++;
      checks++; if (dut_out() !== m_out() || int'(state) !== m_state) begin
        failures++; $display("FAIL decay_track k=%0d out=%0d/%0d state=%0d/%0d", k, dut_out(), m_out(), state, m_state);
      end
`ifndef ADSR_EXP_EN
      if (k == 127) begin
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL decay_k127_state got=%0d want=2", state); end
      end
`endif
    end
`ifndef ADSR_EXP_EN
    checks++; if (k !== 128) begin failures++; $display("FAIL decay_ticks got=%0d want=128", k); end
`endif
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL sustain_state got=%0d want=3", state); end
    checks++; if (dut_out() !== 2048) begin failures++; $display("FAIL sustain_out got=%0d want=2048", dut_out()); end
    sustain = 8'h40;
    tick();
    checks++; if (dut_out() !== 1024) begin failures++; $display("FAIL sustain_change_out got=%0d want=1024", dut_out()); end
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL sustain_change_state got=%0d want=3", state); end
    sustain = 8'h80;
    tick();
    checks++; if (dut_out() !== 2048) begin failures++; $display("FAIL sustain_back_out got=%0d want=2048", dut_out()); end
    smp = NEG;
    tick();
    checks++; if (dut_out() !== -2048) begin failures++; $display("FAIL negative_out got=%0d want=-2048", dut_out()); end
    smp = POS;
  endtask

`ifndef ADSR_EXP_EN
  task automatic test_release();
    gate = 1'b0; rel = 8'h07;
    tick();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL release_edge_state got=%0d want=4", state); end
    checks++; if (dut_out() !== 2048) begin failures++; $display("FAIL release_edge_out got=%0d want=2048", dut_out()); end
    for (int k = 1; k <= 256; k++) begin
      tick();
      checks++; if (dut_out() !== m_out()) begin failures++; $display("FAIL release_out k=%0d got=%0d want=%0d", k, dut_out(), m_out()); end
      if (k == 255) begin
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL release_k255_state got=%0d want=4", state); end
      end
    end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL release_idle_state got=%0d want=0", state); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL release_active got=%0b want=0", active); end
    checks++; if (dut_out() !== 0) begin failures++; $display("FAIL release_out_zero got=%0d want=0", dut_out()); end
  endtask
`else
  task automatic test_exp();
    int prev;
    int n;
    gate = 1'b0; rel = 8'h04;
    tick();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL exp_edge_state got=%0d want=4", state); end
    checks++; if (dut_out() !== 2048) begin failures++; $display("FAIL exp_edge_out got=%0d want=2048", dut_out()); end
    tick();
    checks++; if (dut_out() !== 1904) begin failures++; $display("FAIL exp_first_step_out got=%0d want=1904", dut_out()); end
    prev = dut_out();
    n = 0;
    while (m_state == 4 && n < 3000) begin
      tick();
      n++;
      checks++; if (dut_out() > prev || dut_out() !== m_out()) begin
        failures++; $display("FAIL exp_release n=%0d got=%0d prev=%0d want=%0d", n, dut_out(), prev, m_out());
      end
      prev = dut_out();
    end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL exp_idle_state got=%0d want=0", state); end
    checks++; if (dut_out() !== 0) begin failures++; $display("FAIL exp_idle_out got=%0d want=0", dut_out()); end
  endtask
`endif

  task automatic test_retrigger();
    int n;
    int floor_out;
    gate = 1'b1; attack = 8'hFF; decay = DEC_RATE; sustain = 8'h80; rel = 8'h07;
    n = 0;
    while (m_state != 3 && n < 2500) begin tick(); n++; end
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL retrig_sustain_state got=%0d want=3", state); end
    gate = 1'b0;
    tick();
    n = 0;
    while (m_state == 4 && m_env > 16384 && n < 2000) begin tick(); n++; end
`ifndef ADSR_EXP_EN
    checks++; if (dut_out() !== 1024) begin failures++; $display("FAIL retrig_release_out got=%0d want=1024", dut_out()); end
`endif
    floor_out = m_out();
    gate = 1'b1;
    tick();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL retrig_state got=%0d want=1", state); end
    checks++; if (dut_out() !== floor_out) begin failures++; $display("FAIL retrig_edge_out got=%0d want=%0d", dut_out(), floor_out); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (dut_out() < floor_out || dut_out() !== m_out()) begin
        failures++; $display("FAIL retrig_no_dip k=%0d got=%0d floor=%0d want=%0d", k, dut_out(), floor_out, m_out());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7, 0) == 0) gate = ~gate;
      smp    = 14'($urandom);
      attack = 8'($urandom_range(255, 96));
      decay  = 8'($urandom_range(255, 96));
      rel    = 8'($urandom_range(255, 96));
      if ($urandom_range(15, 0) == 0) sustain = 8'($urandom);
      tick();
      checks++; if (dut_out() !== m_out()) begin failures++; $display("FAIL random_out i=%0d got=%0d want=%0d", i, dut_out(), m_out()); end
      checks++; if (int'(state) !== m_state) begin failures++; $display("FAIL random_state i=%0d got=%0d want=%0d", i, state, m_state); end
      checks++; if (active !== (m_state != 0)) begin failures++; $display("FAIL random_active i=%0d got=%0b want=%0b", i, active, m_state != 0); end
    end
  endtask

  initial begin
    rst = 1'b0; sample_en = 1'b0; gate = 1'b0; smp = '0;
    attack = '0; decay = '0; sustain = '0; rel = '0;
    m_env = 0; m_state = 0; m_gq = 1'b0; m_in = 0;
    test_reset();
    test_attack();
    test_decay_sustain();
`ifndef ADSR_EXP_EN
    test_release();
`else
    test_exp();
`endif
    test_retrigger();
    gate = 1'b0;
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
